// File: rtl/significand_normalize_round_subtraction_if.sv
// Handshake bundle for the decimal32 post-subtraction normalize/round stage.
//
// Input channel  (master -> slave): in_valid, diff, GRS_bits, exp_in, sign_in
//                (slave -> master): in_ready
// Output channel (slave -> master): out_valid, result, exp_out, sign_out,
//                                   inexact, underflow, overflow
//                (master -> slave): out_ready
//
// The stage itself uses the slave modport; whoever feeds operands in and
// takes results out uses the master modport.
interface significand_normalize_round_subtraction_if #(
    parameter int DIGITS = 7,
    parameter int EXP_W  = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [4*DIGITS-1:0]   diff;
    logic [8:0]            GRS_bits;
    logic [EXP_W-1:0]      exp_in;
    logic                  sign_in;

    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   result;
    logic [EXP_W-1:0]      exp_out;
    logic                  sign_out;
    logic                  inexact;
    logic                  underflow;
    logic                  overflow;

    modport master (
        output in_valid, diff, GRS_bits, exp_in, sign_in, out_ready,
        input  in_ready, out_valid, result, exp_out, sign_out,
               inexact, underflow, overflow
    );

    modport slave (
        input  in_valid, diff, GRS_bits, exp_in, sign_in, out_ready,
        output in_ready, out_valid, result, exp_out, sign_out,
               inexact, underflow, overflow
    );
endinterface

// File: rtl/significand_normalize_round_subtraction.sv
// Post-subtraction stage of the decimal32 subtractor.
//
// Takes the BCD magnitude of a significand difference together with the guard
// digit, round digit and sticky bit from alignment, left-normalizes it one
// digit per cycle, applies round-half-even and hands back the final
// significand, exponent, sign and exception flags.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; aborts any operation in flight
//   bus    slave side of the handshake bundle:
//            in_valid/in_ready + diff, GRS_bits, exp_in, sign_in   (operand)
//            out_valid/out_ready + result, exp_out, sign_out,
//            inexact, underflow, overflow                          (result)
//
// Timing: operand accepted in cycle t gives out_valid in cycle t+3+k, where k
// (0..DIGITS+1) is the number of digit shifts needed.
module significand_normalize_round_subtraction #(
    parameter int DIGITS  = 7,
    parameter int EXP_W   = 8,
    parameter int EXP_MAX = 191
) (
    input  logic clk,
    input  logic rst_n,
    significand_normalize_round_subtraction_if.slave bus
);

    localparam int SIG_W  = 4 * DIGITS;
    localparam int WORK_W = 4 * (DIGITS + 2);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        ROUND,
        DONE
    } state_t;

    state_t              state;

    // Working copy: significand digits followed by guard and round digits.
    logic [WORK_W-1:0]   work;
    logic                sticky;
    logic [EXP_W-1:0]    exp_work;
    logic                sign_work;
    logic [3:0]          shift_count;

    logic                out_valid_r;
    logic [SIG_W-1:0]    result_r;
    logic [EXP_W-1:0]    exp_out_r;
    logic                sign_out_r;
    logic                inexact_r;
    logic                underflow_r;
    logic                overflow_r;

    logic [SIG_W-1:0]    upper;
    logic [SIG_W-1:0]    incremented;
    logic [SIG_W-1:0]    rounded;
    logic [EXP_W-1:0]    exp_rounded;
    logic [3:0]          g_digit;
    logic [3:0]          r_digit;
    logic                round_up;
    logic                carry;
    logic                inexact_c;
    logic                overflow_c;
    logic                underflow_c;
    logic [3:0]          msd;

    assign msd = work[WORK_W-1 -: 4];

    // Round-half-even on the top DIGITS digits of the working register.
    // The increment ripples a decimal carry from the least significant digit;
    // a carry out of the top digit means the significand was all nines.
    always_comb begin
        upper    = work[WORK_W-1 -: SIG_W];
        g_digit  = work[7:4];
        r_digit  = work[3:0];
        round_up = (g_digit > 4'd5)
                 | ((g_digit == 4'd5) & ((r_digit != 4'd0) | sticky))
                 | ((g_digit == 4'd5) & (r_digit == 4'd0) & !sticky & upper[0]);

        carry       = round_up;
        incremented = upper;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (upper[4*i +: 4] == 4'd9) begin
                    incremented[4*i +: 4] = 4'd0;
                end else begin
                    incremented[4*i +: 4] = upper[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end

        rounded     = incremented;
        exp_rounded = exp_work;
        overflow_c  = 1'b0;
        if (carry) begin
            if (exp_work == EXP_W'(EXP_MAX)) begin
                rounded    = {DIGITS{4'h9}};
                overflow_c = 1'b1;
            end else begin
                rounded     = {4'd1, {(SIG_W-4){1'b0}}};
                exp_rounded = exp_work + EXP_W'(1);
            end
        end

        inexact_c   = (g_digit != 4'd0) | (r_digit != 4'd0) | sticky;
        underflow_c = (rounded[SIG_W-1 -: 4] == 4'd0) & inexact_c;
    end

    // Control and datapath. The sticky bit stays beside the round digit and is
    // never shifted into the working register; the exponent stops the shift
    // at zero so that subnormal-looking results keep their remaining digits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            work        <= '0;
            sticky      <= 1'b0;
            exp_work    <= '0;
            sign_work   <= 1'b0;
            shift_count <= 4'd0;
            out_valid_r <= 1'b0;
            result_r    <= '0;
            exp_out_r   <= '0;
            sign_out_r  <= 1'b0;
            inexact_r   <= 1'b0;
            underflow_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        work        <= {bus.diff, bus.GRS_bits[8:1]};
                        sticky      <= bus.GRS_bits[0];
                        exp_work    <= bus.exp_in;
                        sign_work   <= bus.sign_in;
                        shift_count <= 4'd0;
                        state       <= SHIFT;
                    end
                end
                SHIFT: begin
                    if ((work == '0) && !sticky) begin
                        sign_work <= 1'b0;
                        state     <= ROUND;
                    end else if ((msd != 4'd0) || (exp_work == '0) ||
                                 (shift_count == 4'(DIGITS + 1))) begin
                        state <= ROUND;
                    end else begin
                        work        <= {work[WORK_W-5:0], 4'd0};
                        exp_work    <= exp_work - EXP_W'(1);
                        shift_count <= shift_count + 4'd1;
                    end
                end
                ROUND: begin
                    result_r    <= rounded;
                    exp_out_r   <= exp_rounded;
                    sign_out_r  <= sign_work;
                    inexact_r   <= inexact_c;
                    underflow_r <= underflow_c;
                    overflow_r  <= overflow_c;
                    out_valid_r <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = out_valid_r;
    assign bus.result    = result_r;
    assign bus.exp_out   = exp_out_r;
    assign bus.sign_out  = sign_out_r;
    assign bus.inexact   = inexact_r;
    assign bus.underflow = underflow_r;
    assign bus.overflow  = overflow_r;

endmodule

// File: tb/tb_significand_normalize_round_subtraction.sv
// Self-checking bench for significand_normalize_round_subtraction.
// Directed cases use hand-worked expectations; random operands are checked
// against an integer-arithmetic model of normalize + round-half-even.
module tb_significand_normalize_round_subtraction;

    typedef struct {
        logic [27:0] res;
        logic [7:0]  exp;
        logic        sign;
        logic        inx;
        logic        unf;
        logic        ovf;
        int          lat;
    } expect_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    significand_normalize_round_subtraction_if bus ();

    significand_normalize_round_subtraction dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic expect_t mk(input logic [27:0] res, input logic [7:0] exp,
                                   input logic sign, input logic inx, input logic unf,
                                   input logic ovf, input int lat);
        expect_t x;
        x.res = res; x.exp = exp; x.sign = sign;
        x.inx = inx; x.unf = unf; x.ovf = ovf; x.lat = lat;
        return x;
    endfunction

    function automatic longint bcd_to_int(input logic [27:0] d);
        longint v = 0;
        for (int i = 6; i >= 0; i--) v = v * 10 + longint'(d[4*i +: 4]);
        return v;
    endfunction

    function automatic logic [27:0] int_to_bcd(input longint v);
        logic [27:0] d = '0;
        longint t = v;
        for (int i = 0; i < 7; i++) begin
            d[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return d;
    endfunction

    // Treat the nine digits as one integer: multiply by ten while the leading
    // digit is zero, then round the last two digits away half-to-even.
    function automatic expect_t ref_model(input logic [27:0] d, input logic [3:0] g,
                                          input logic [3:0] r, input logic s,
                                          input logic [7:0] e, input logic sg);
        expect_t x;
        longint n, upper;
        int rem, ex, k;
        logic up;
        n  = bcd_to_int(d) * 100 + longint'(g) * 10 + longint'(r);
        ex = int'(e);
        k  = 0;
        if (n == 0 && !s) return mk(28'h0, e, 1'b0, 1'b0, 1'b0, 1'b0, 3);
        while (n < 100000000 && ex > 0 && k < 8) begin
            n = n * 10; ex--; k++;
        end
        upper = n / 100;
        rem   = int'(n % 100);
        up    = (rem > 50) || (rem == 50 && (s || (upper % 2 == 1)));
        if (up) upper = upper + 1;
        x.ovf = 1'b0;
        if (upper == 10000000) begin
            if (ex == 191) begin
                upper = 9999999; x.ovf = 1'b1;
            end else begin
                upper = 1000000; ex++;
            end
        end
        x.inx  = (rem != 0) || s;
        x.unf  = (upper < 1000000) && x.inx;
        x.res  = int_to_bcd(upper);
        x.exp  = 8'(ex);
        x.sign = sg;
        x.lat  = k + 3;
        return x;
    endfunction

    task automatic applyStimulus(input logic [27:0] d, input logic [8:0] grs,
                                 input logic [7:0] e, input logic sg);
        int wait_cnt = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.diff     = d;
        bus.GRS_bits = grs;
        bus.exp_in   = e;
        bus.sign_in  = sg;
        while (bus.in_ready !== 1'b1 && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.diff     = 28'($urandom);
        bus.GRS_bits = 9'($urandom);
        bus.exp_in   = 8'($urandom);
        bus.sign_in  = 1'($urandom);
    endtask

    task automatic checkOutput(input string name, input expect_t x, input int stall);
        int cnt = 0;
        do begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
        end while (bus.out_valid !== 1'b1 && cnt < 40);
        check({name, ".latency"},   32'(cnt + 1),       32'(x.lat));
        check({name, ".result"},    32'(bus.result),    32'(x.res));
        check({name, ".exp"},       32'(bus.exp_out),   32'(x.exp));
        check({name, ".sign"},      32'(bus.sign_out),  32'(x.sign));
        check({name, ".inexact"},   32'(bus.inexact),   32'(x.inx));
        check({name, ".underflow"}, 32'(bus.underflow), 32'(x.unf));
        check({name, ".overflow"},  32'(bus.overflow),  32'(x.ovf));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check({name, ".hold_valid"},  32'(bus.out_valid), 32'd1);
            check({name, ".hold_result"}, 32'(bus.result),    32'(x.res));
            check({name, ".hold_exp"},    32'(bus.exp_out),   32'(x.exp));
            check({name, ".hold_ready"},  32'(bus.in_ready),  32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check({name, ".valid_after_pop"},    32'(bus.out_valid), 32'd0);
        check({name, ".in_ready_after_pop"}, 32'(bus.in_ready),  32'd1);
    endtask

    initial begin
        expect_t x;
        logic [3:0] digits [9];
        logic [27:0] d;
        logic [3:0] g, r;
        logic s, sg;
        logic [7:0] e;
        int lz, sel;

        bus.in_valid  = 1'b0;
        bus.diff      = '0;
        bus.GRS_bits  = '0;
        bus.exp_in    = '0;
        bus.sign_in   = 1'b0;
        bus.out_ready = 1'b0;

        repeat (3) @(negedge clk);
        check("reset.out_valid", 32'(bus.out_valid), 32'd0);
        check("reset.result",    32'(bus.result),    32'd0);
        check("reset.in_ready",  32'(bus.in_ready),  32'd1);
        rst_n = 1'b1;

        // Four digit shifts, exact.
        applyStimulus(28'h0000123, 9'h000, 8'd10, 1'b0);
        checkOutput("case1", mk(28'h1230000, 8'd6, 1'b0, 1'b0, 1'b0, 1'b0, 7), 0);

        // Exact tie with an odd last digit rounds up.
        applyStimulus(28'h1234567, {4'd5, 4'd0, 1'b0}, 8'd50, 1'b0);
        checkOutput("case2", mk(28'h1234568, 8'd50, 1'b0, 1'b1, 1'b0, 1'b0, 3), 0);

        // All nines carry out: exponent bump, then overflow at the top.
        applyStimulus(28'h9999999, {4'd6, 4'd0, 1'b0}, 8'd20, 1'b1);
        checkOutput("case3a", mk(28'h1000000, 8'd21, 1'b1, 1'b1, 1'b0, 1'b0, 3), 0);
        applyStimulus(28'h9999999, {4'd6, 4'd0, 1'b0}, 8'd191, 1'b0);
        checkOutput("case3b", mk(28'h9999999, 8'd191, 1'b0, 1'b1, 1'b0, 1'b1, 3), 0);

        // Exponent reaches zero after two shifts.
        applyStimulus(28'h0001234, {4'd7, 4'd8, 1'b1}, 8'd2, 1'b0);
        checkOutput("case4", mk(28'h0123478, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 5), 0);

        // Reset in the middle of a shifting operation.
        applyStimulus(28'h0000123, 9'h000, 8'd10, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("case6.out_valid", 32'(bus.out_valid), 32'd0);
        check("case6.result",    32'(bus.result),    32'd0);
        check("case6.exp",       32'(bus.exp_out),   32'd0);
        check("case6.inexact",   32'(bus.inexact),   32'd0);
        check("case6.underflow", 32'(bus.underflow), 32'd0);
        check("case6.in_ready",  32'(bus.in_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(28'h1234567, {4'd5, 4'd0, 1'b0}, 8'd50, 1'b0);
        checkOutput("case6_after", mk(28'h1234568, 8'd50, 1'b0, 1'b1, 1'b0, 1'b0, 3), 0);

        // Negative zero becomes positive zero; downstream stalls five cycles.
        applyStimulus(28'h0000000, 9'h000, 8'd40, 1'b1);
        checkOutput("case5", mk(28'h0000000, 8'd40, 1'b0, 1'b0, 1'b0, 1'b0, 3), 5);

        for (int i = 0; i < 40; i++) begin
            lz = $urandom_range(0, 9);
            for (int j = 0; j < 9; j++)
                digits[j] = (j < lz) ? 4'd0 : 4'($urandom_range(0, 9));
            d = {digits[0], digits[1], digits[2], digits[3], digits[4], digits[5], digits[6]};
            g = digits[7];
            r = digits[8];
            s = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) begin
                d = 28'h9999999;
                g = 4'($urandom_range(5, 9));
            end
            sel = $urandom_range(0, 5);
            if (sel == 0)      e = 8'd191;
            else if (sel == 1) e = 8'($urandom_range(0, 3));
            else               e = 8'($urandom_range(0, 191));
            sg = 1'($urandom_range(0, 1));
            x = ref_model(d, g, r, s, e, sg);
            applyStimulus(d, {g, r, s}, e, sg);
            checkOutput($sformatf("rand%0d", i), x, $urandom_range(0, 2));
        end

        $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
